regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the register file's single write port. Collects write requests from NUM_REQ producers (e.g. ALU, load unit, CSR unit) over valid/ready handshakes. Grants one per cycle by round-robin into a one-entry output register that drives wr_reg_en/wr_reg_addr/wr_wdata. Supports a write-back stall that freezes the write port without losing data.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and widths used by the write-back path.
package regfile_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;

  // One write-back request as seen by the register file.
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  // Performance counter width.
  typedef logic [15:0] perf_cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request bit found scanning
// upward from rr_ptr+1, wrapping modulo NUM_REQ. No grant when en is low.
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    gnt_idx
);

  // Scan positions rr_ptr+1 .. rr_ptr+NUM_REQ; the last one is rr_ptr itself.
  always_comb begin
    logic          found;
    int            pos;
    logic [IDXW-1:0] j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    j       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(rr_ptr) + k) % NUM_REQ;
      j   = IDXW'(pos);
      if (en && !found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Round-robin grant into a one-entry output register; wb_stall freezes the
// entry without dropping it. Address 0 is accepted but never written.
// Optional: define WB_ARB_PERF_CNT_EN to add the conflict_cnt port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ    = 3,
  parameter  int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter  int DATAWIDTH  = REG_DATA_WIDTH,
  localparam int IDXW       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]    req_wdata,
  input  logic                            wb_stall,
  output logic                            wr_reg_en,
  output logic [ADDR_WIDTH-1:0]           wr_reg_addr,
  output logic [DATAWIDTH-1:0]            wr_wdata,
`ifdef WB_ARB_PERF_CNT_EN
  output logic [15:0]                     conflict_cnt,
`endif
  output logic [IDXW-1:0]                 grant_id
);

  logic                  out_vld;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATAWIDTH-1:0]  out_data;
  logic [IDXW-1:0]       rr_ptr;
  logic                  load_ok;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDXW-1:0]       arb_idx;
  logic                  xfer;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATAWIDTH-1:0]  data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[i] = req_wdata[i*DATAWIDTH +: DATAWIDTH];
  end

  // The entry can be replaced when empty or when it drains this cycle.
  assign load_ok = ~out_vld | ~wb_stall;

  // rst_n gates the enable so no requester sees ready while in reset.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .en      (load_ok & rst_n),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign req_ready   = arb_gnt;
  assign xfer        = |arb_gnt;

  // x0 is architecturally zero: the entry occupies the stage but never writes.
  assign wr_reg_en   = rst_n & out_vld & ~wb_stall & (out_addr != '0);
  assign wr_reg_addr = out_addr;
  assign wr_wdata    = out_data;

  // Output register and round-robin pointer; everything holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      grant_id <= '0;
      rr_ptr   <= IDXW'(NUM_REQ - 1);
    end else if (load_ok) begin
      out_vld <= xfer;
      if (xfer) begin
        out_addr <= addr_arr[arb_idx];
        out_data <= data_arr[arb_idx];
        grant_id <= arb_idx;
        rr_ptr   <= arb_idx;
      end
    end
  end

`ifdef WB_ARB_PERF_CNT_EN
  perf_cnt_t cnt_q;

  // Saturating count of cycles where two or more requesters compete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (($countones(req_valid) > 1) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

`ifndef SYNTHESIS
  // Requesters must hold their request stable until it is accepted.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold_chk
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(addr_arr[i]) && $stable(data_arr[i])));
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a requester model issues
// randomized and directed traffic, a reference model of the arbiter rules
// predicts ready/write-enable each cycle, and accepted non-zero writes go to a
// scoreboard queue that a separate monitor drains against the write port.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N  = 3;
  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = REG_DATA_WIDTH;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            wb_stall;
  logic            wr_reg_en;
  logic [AW-1:0]   wr_reg_addr;
  logic [DW-1:0]   wr_wdata;
  logic [IW-1:0]   grant_id;
`ifdef WB_ARB_PERF_CNT_EN
  logic [15:0]     conflict_cnt;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATAWIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .wb_stall    (wb_stall),
    .wr_reg_en   (wr_reg_en),
    .wr_reg_addr (wr_reg_addr),
    .wr_wdata    (wr_wdata),
`ifdef WB_ARB_PERF_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    wb_req_t req;
    int      id;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;

  // requester model
  bit            pend   [N];
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];
  int            spawn_pct  = 0;
  bit            zero_ok    = 1'b1;
  logic [N-1:0]  spawn_mask = '1;

  // reference model of the output stage
  bit            m_vld;
  logic [AW-1:0] m_addr;
  int            m_ptr;
  int            m_cnt;
  int            last_gnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_addr[i*AW +: AW]   = r_addr[i];
      req_wdata[i*DW +: DW]  = r_data[i];
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i]   = 1'b1;
    r_addr[i] = a;
    r_data[i] = d;
  endtask

  // One clock cycle: new requests, drive, predict, compare, advance model.
  task automatic step(input bit stall);
    logic [N-1:0] exp_rdy;
    bit ld;
    int g;
    int nv;
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && spawn_mask[i] && ($urandom_range(1, 100) <= spawn_pct)) begin
        pend[i]   = 1'b1;
        r_addr[i] = zero_ok ? AW'($urandom_range(0, 31)) : AW'($urandom_range(1, 31));
        r_data[i] = $urandom;
      end
    end
    drive();
    wb_stall = stall;
    #1;
    ld = !m_vld || !stall;
    chk("wr_reg_en", wr_reg_en, (m_vld && !stall && m_addr != 0));
    g = -1;
    if (ld) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && pend[j]) g = j;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    nv = 0;
    for (int i = 0; i < N; i++) nv += pend[i];
`ifdef WB_ARB_PERF_CNT_EN
    chk("conflict_cnt", conflict_cnt, m_cnt);
`endif
    if (nv >= 2 && m_cnt < 65535) m_cnt++;
    last_gnt = g;
    if (ld) begin
      if (g >= 0) begin
        exp_t e;
        m_vld  = 1'b1;
        m_addr = r_addr[g];
        m_ptr  = g;
        if (r_addr[g] != 0) begin
          e.req.addr  = r_addr[g];
          e.req.wdata = r_data[g];
          e.id        = g;
          q.push_back(e);
        end
        pend[g] = 1'b0;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  // Reset asserted between edges; requests are withdrawn while in reset.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst wr_reg_en", wr_reg_en, 0);
    chk("rst req_ready", req_ready, 0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    wb_stall = 1'b0;
    q.delete();
    m_vld = 1'b0;
    m_addr = '0;
    m_ptr = N - 1;
    m_cnt = 0;
    @(posedge clk);
    #1;
    chk("rst grant_id", grant_id, 0);
    chk("rst wr_reg_addr", wr_reg_addr, 0);
    chk("rst wr_wdata", wr_wdata, 0);
`ifdef WB_ARB_PERF_CNT_EN
    chk("rst conflict_cnt", conflict_cnt, 0);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every write the DUT issues must match the oldest accepted request.
  initial begin
    forever begin
      @(posedge clk);
      #4;
      if (rst_n && wr_reg_en) begin
        if (q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected write: addr %0h data %0h expected none", wr_reg_addr, wr_wdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb addr", wr_reg_addr, e.req.addr);
          chk("wb data", wr_wdata, e.req.wdata);
          chk("wb grant_id", grant_id, e.id);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      r_addr[i] = '0;
      r_data[i] = '0;
    end
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    wb_stall  = 1'b0;
    #3;
    do_reset();

    // single request
    set_req(0, 5, 32'hDEADBEEF);
    step(0);
    chk("single ready", req_ready, 3'b001);
    step(0);
    chk("single wr_en", wr_reg_en, 1);
    chk("single addr", wr_reg_addr, 5);
    chk("single data", wr_wdata, 32'hDEADBEEF);
    chk("single grant_id", grant_id, 0);

    // fairness with all requesters valid
    do_reset();
    spawn_pct = 100;
    zero_ok = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(0);
      chk("fair order", last_gnt, c % 3);
    end

    // stall holds addr 7, then drains on release with a new grant
    spawn_pct = 0;
    do_reset();
    set_req(0, 7, 32'h0000_0777);
    step(0);
    set_req(1, 3, 32'h1111_0001);
    set_req(2, 4, 32'h2222_0002);
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("stall addr", wr_reg_addr, 7);
      chk("stall ready", req_ready, 0);
    end
    step(0);
    chk("release addr", wr_reg_addr, 7);
    chk("release grant", last_gnt, 1);
    repeat (3) step(0);

    // x0 accepted, not written, but advances the pointer
    do_reset();
    set_req(1, 0, 32'h1234);
    step(0);
    chk("x0 ready", req_ready, 3'b010);
    set_req(1, 9, 32'h9999);
    set_req(2, 10, 32'hAAAA);
    step(0);
    chk("x0 no write", wr_reg_en, 0);
    chk("x0 next grant", last_gnt, 2);
    repeat (3) step(0);

    // randomized traffic with random stalls
    spawn_pct = 60;
    zero_ok = 1'b1;
    for (int c = 0; c < 2000; c++) step($urandom_range(0, 3) == 0);

    // async reset in the middle of a full burst
    spawn_pct = 100;
    repeat (4) step(0);
    #3;
    do_reset();
    step(0);
    chk("post-reset grant", last_gnt, 0);

`ifdef WB_ARB_PERF_CNT_EN
    do_reset();
    spawn_mask = 3'b011;
    repeat (11) step(0);
    chk("conflict 10", conflict_cnt, 10);
    repeat (65540) step(0);
    chk("conflict sat", conflict_cnt, 16'hFFFF);
    spawn_mask = '1;
`endif

    // drain and confirm every accepted write came out
    spawn_pct = 0;
    repeat (8) step(0);
    chk("scoreboard empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
